// File: rtl/load_store_unit.sv
// Data memory for an RV32I load/store path: byte-addressable word array with
// combinational loads, clocked stores and sticky alignment/range fault reporting.
module load_store_unit #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Read_i,
    input  logic        Mem_Write_i,
    input  logic [2:0]  Funct3_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    input  logic        Err_Clear_i,
    output logic [31:0] Read_Data_o,
    output logic        Misaligned_o,
    output logic        Range_Error_o,
    output logic [31:0] Fault_Addr_o
);

    localparam int unsigned IDX_W      = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(4 * MEMORY_DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } size_e;

    logic [31:0] mem_q [MEMORY_DEPTH];

    logic        misaligned_q, misaligned_d;
    logic        range_err_q,  range_err_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             misaligned;
    size_e            size;

    logic load_defined, store_defined;
    logic load_act, store_act, access_act, access_ok;
    logic fault_mis, fault_rng, fault;

    logic [31:0] rd_word, rd_shifted, read_data;
    logic [3:0]  wr_mask;
    logic [31:0] wr_bits, wr_data, wr_word;
    logic        wr_en;

    // Address decode relative to the window; BASE_ADDR is word aligned so the
    // low offset bits are also the byte lane.
    assign offset   = Address_i - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];
    assign lane     = offset[1:0];
    assign in_range = (Address_i >= BASE_ADDR) && (offset < SPAN_BYTES);
    assign size     = size_e'(Funct3_i[1:0]);

    assign load_defined  = (Funct3_i != 3'b011) && (Funct3_i[2:1] != 2'b11);
    assign store_defined = !Funct3_i[2] && (Funct3_i[1:0] != 2'b11);

    assign misaligned = ((size == SZ_HALF) && lane[0]) ||
                        ((size == SZ_WORD) && (lane != 2'b00));

    // Undefined encodings never count as an access, so they cannot raise a flag.
    assign load_act   = Mem_Read_i  && load_defined;
    assign store_act  = Mem_Write_i && store_defined;
    assign access_act = load_act || store_act;
    assign access_ok  = in_range && !misaligned;

    assign fault_mis = access_act && misaligned;
    assign fault_rng = access_act && !in_range;
    assign fault     = fault_mis || fault_rng;

    assign rd_word    = in_range ? mem_q[word_idx] : '0;
    assign rd_shifted = rd_word >> {lane, 3'b000};

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        read_data = '0;
        if (load_act && access_ok) begin
            unique case (Funct3_i)
                3'b000:  read_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
                3'b001:  read_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
                3'b010:  read_data = rd_word;
                3'b100:  read_data = {24'h0, rd_shifted[7:0]};
                3'b101:  read_data = {16'h0, rd_shifted[15:0]};
                default: read_data = '0;
            endcase
        end
    end

    assign Read_Data_o = read_data;

    always_comb begin
        wr_mask = 4'b0000;
        wr_data = '0;
        unique case (size)
            SZ_BYTE: begin
                wr_mask = 4'b0001 << lane;
                wr_data = {4{Write_Data_i[7:0]}};
            end
            SZ_HALF: begin
                wr_mask = 4'b0011 << {lane[1], 1'b0};
                wr_data = {2{Write_Data_i[15:0]}};
            end
            SZ_WORD: begin
                wr_mask = 4'b1111;
                wr_data = Write_Data_i;
            end
            default: begin
                wr_mask = 4'b0000;
                wr_data = '0;
            end
        endcase
    end

    // Read-modify-write merge keeps unaddressed bytes of the word intact.
    assign wr_bits = {{8{wr_mask[3]}}, {8{wr_mask[2]}}, {8{wr_mask[1]}}, {8{wr_mask[0]}}};
    assign wr_word = (rd_word & ~wr_bits) | (wr_data & wr_bits);
    assign wr_en   = store_act && access_ok;

    // NOTE: storage is flops, not a RAM macro, because reset must clear every word asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            // NOTE: sequential state is always assigned with <= so all flops update together.
            mem_q[word_idx] <= wr_word;
        end
    end

    // A clear coinciding with a fault restarts the record from that fault.
    always_comb begin
        misaligned_d = misaligned_q;
        range_err_d  = range_err_q;
        fault_addr_d = fault_addr_q;
        if (Err_Clear_i) begin
            misaligned_d = fault_mis;
            range_err_d  = fault_rng;
            fault_addr_d = fault ? Address_i : '0;
        end else if (fault) begin
            misaligned_d = misaligned_q || fault_mis;
            range_err_d  = range_err_q  || fault_rng;
            if (!misaligned_q && !range_err_q) begin
                fault_addr_d = Address_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned_q <= 1'b0;
            range_err_q  <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            misaligned_q <= misaligned_d;
            range_err_q  <= range_err_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign Misaligned_o  = misaligned_q;
    assign Range_Error_o = range_err_q;
    assign Fault_Addr_o  = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference model compared every cycle,
// plus directed accesses with hand-computed expected values.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write, err_clear;
    logic [2:0]  funct3;
    logic [31:0] address, write_data;
    logic [31:0] read_data, fault_addr;
    logic        misaligned, range_error;

    int tests  = 0;
    int failed = 0;
    bit run_cmp = 0;

    logic [7:0] mbytes [0:4*DEPTH-1];
    bit         m_mis, m_rng;
    logic [31:0] m_fa;

    load_store_unit #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .Mem_Read_i    (mem_read),
        .Mem_Write_i   (mem_write),
        .Funct3_i      (funct3),
        .Address_i     (address),
        .Write_Data_i  (write_data),
        .Err_Clear_i   (err_clear),
        .Read_Data_o   (read_data),
        .Misaligned_o  (misaligned),
        .Range_Error_o (range_error),
        .Fault_Addr_o  (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit load_ok(input logic [2:0] f3);
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    function automatic bit store_ok(input logic [2:0] f3);
        return f3 inside {3'b000, 3'b001, 3'b010};
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint la, lo, hi;
        la = longint'(a);
        lo = longint'(BASE);
        hi = lo + 4 * longint'(DEPTH) - 1;
        return (la >= lo) && (la <= hi);
    endfunction

    function automatic logic [31:0] model_read();
        int sz;
        int off;
        logic [31:0] v;
        if (!mem_read || !load_ok(funct3)) return 32'h0;
        sz = acc_size(funct3);
        if (!in_rng(address) || (address % 32'(sz)) != 0) return 32'h0;
        off = int'(address - BASE);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mbytes[off+i]) << (8 * i));
        if (!funct3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    task automatic model_edge();
        bit la, sa, act, fm, fr, first;
        int sz;
        int off;
        la  = mem_read && load_ok(funct3);
        sa  = mem_write && store_ok(funct3);
        act = la || sa;
        sz  = acc_size(funct3);
        fm  = act && ((address % 32'(sz)) != 0);
        fr  = act && !in_rng(address);
        if (err_clear) begin
            m_mis = fm;
            m_rng = fr;
            m_fa  = (fm || fr) ? address : 32'h0;
        end else if (fm || fr) begin
            first = !m_mis && !m_rng;
            m_mis = m_mis || fm;
            m_rng = m_rng || fr;
            if (first) m_fa = address;
        end
        if (sa && !fm && !fr) begin
            off = int'(address - BASE);
            for (int i = 0; i < sz; i++) mbytes[off+i] = write_data[8*i +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4 * int'(DEPTH); i++) mbytes[i] = 8'h00;
        m_mis = 0;
        m_rng = 0;
        m_fa  = 32'h0;
    endtask

    initial model_clear();
    always @(negedge reset) model_clear();
    always @(posedge clk) if (reset === 1'b1) model_edge();

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (run_cmp && reset === 1'b1) begin
            check("cmp_read_data",  read_data,          model_read());
            check("cmp_misaligned", 32'(misaligned),    32'(m_mis));
            check("cmp_range_err",  32'(range_error),   32'(m_rng));
            check("cmp_fault_addr", fault_addr,         m_fa);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic clr);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = a;
        write_data = wd;
        err_clear  = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #12 reset = 1'b1;
        #1;
        check("rst_misaligned", 32'(misaligned),  32'h0);
        check("rst_range_err",  32'(range_error), 32'h0);
        check("rst_fault_addr", fault_addr,       32'h0);
        drive(1, 0, 3'b010, BASE, 0, 0); #1;
        check("rst_mem_word0", read_data, 32'h0);
        run_cmp = 1;
        step();

        // word store, then full / signed byte / unsigned byte loads
        drive(0, 1, 3'b010, 32'h1001_0004, 32'hDEAD_BEEF, 0); step();
        drive(1, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("lw_0004", read_data, 32'hDEAD_BEEF);
        drive(1, 0, 3'b000, 32'h1001_0007, 0, 0); #1;
        check("lb_0007", read_data, 32'hFFFF_FFDE);
        drive(1, 0, 3'b100, 32'h1001_0007, 0, 0); #1;
        check("lbu_0007", read_data, 32'h0000_00DE);

        // halfword store into the upper half
        drive(0, 1, 3'b001, 32'h1001_0006, 32'h0000_1234, 0); step();
        drive(1, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("lw_after_sh", read_data, 32'h1234_BEEF);
        drive(1, 0, 3'b001, 32'h1001_0004, 0, 0); #1;
        check("lh_0004", read_data, 32'hFFFF_BEEF);
        drive(1, 0, 3'b101, 32'h1001_0006, 0, 0); #1;
        check("lhu_0006", read_data, 32'h0000_1234);

        // last in-range word
        drive(0, 1, 3'b010, 32'h1001_00FC, 32'hA5A5_5A5A, 0); step();
        drive(1, 0, 3'b010, 32'h1001_00FC, 0, 0); #1;
        check("lw_last_word", read_data, 32'hA5A5_5A5A);
        drive(1, 0, 3'b100, 32'h1001_00FF, 0, 0); #1;
        check("lbu_last_byte", read_data, 32'h0000_00A5);
        drive(1, 0, 3'b000, 32'h1001_00FF, 0, 0); #1;
        check("lb_last_byte", read_data, 32'hFFFF_FFA5);

        // same-cycle load and store: old data visible, new data next cycle
        drive(0, 1, 3'b000, 32'h1001_0008, 32'h0000_0080, 0); step();
        drive(1, 1, 3'b000, 32'h1001_0008, 32'h0000_0055, 0); #1;
        check("rw_same_cycle_old", read_data, 32'hFFFF_FF80);
        step();
        drive(1, 0, 3'b100, 32'h1001_0008, 0, 0); #1;
        check("lbu_after_rw", read_data, 32'h0000_0055);

        // undefined encodings and idle read port
        drive(1, 0, 3'b011, 32'h1001_0004, 0, 0); #1;
        check("undef_load_011", read_data, 32'h0);
        drive(1, 0, 3'b110, 32'h1001_0004, 0, 0); #1;
        check("undef_load_110", read_data, 32'h0);
        drive(0, 1, 3'b111, 32'h1001_0004, 32'hFFFF_FFFF, 0); step();
        drive(1, 1, 3'b111, 32'h1001_0003, 32'hFFFF_FFFF, 0); step();
        check("undef_no_mis", 32'(misaligned),  32'h0);
        check("undef_no_rng", 32'(range_error), 32'h0);
        drive(0, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("no_read_zero", read_data, 32'h0);
        drive(1, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("undef_no_write", read_data, 32'h1234_BEEF);

        // misaligned load, then out-of-range store
        drive(1, 0, 3'b010, 32'h1001_0002, 0, 0); #1;
        check("lw_misaligned_zero", read_data, 32'h0);
        step();
        check("mis_set",        32'(misaligned),  32'h1);
        check("mis_rng_clear",  32'(range_error), 32'h0);
        check("mis_fault_addr", fault_addr,       32'h1001_0002);
        drive(0, 1, 3'b010, 32'h1001_0101, 32'h1111_1111, 0); step();
        check("rng_set",        32'(range_error), 32'h1);
        check("rng_mis_kept",   32'(misaligned),  32'h1);
        check("rng_fault_addr", fault_addr,       32'h1001_0002);
        drive(1, 0, 3'b010, 32'h1001_0100, 0, 0); #1;
        check("lw_past_end", read_data, 32'h0);
        drive(1, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("storage_unchanged", read_data, 32'h1234_BEEF);
        drive(1, 0, 3'b100, 32'h1000_FFFF, 0, 0); #1;
        check("lbu_below_base", read_data, 32'h0);
        idle();

        // clear together with a new misaligned store
        drive(0, 1, 3'b001, 32'h1001_0003, 32'h0000_BEEF, 1); step();
        check("clr_fault_mis",  32'(misaligned),  32'h1);
        check("clr_fault_rng",  32'(range_error), 32'h0);
        check("clr_fault_addr", fault_addr,       32'h1001_0003);
        drive(0, 0, 3'b000, 32'h0, 0, 1); step();
        check("clr_mis",  32'(misaligned), 32'h0);
        check("clr_addr", fault_addr,      32'h0);

        // below-window access records a pure range fault
        drive(1, 0, 3'b000, 32'h1000_FFFF, 0, 0); step();
        check("below_rng",  32'(range_error), 32'h1);
        check("below_mis",  32'(misaligned),  32'h0);
        check("below_addr", fault_addr,       32'h1000_FFFF);

        // asynchronous reset mid-cycle after stores and with flags set
        drive(0, 1, 3'b010, 32'h1001_0010, 32'hCAFE_F00D, 0); step();
        drive(1, 0, 3'b010, 32'h1001_0010, 0, 0); #1;
        check("pre_reset_word", read_data, 32'hCAFE_F00D);
        #1 reset = 1'b0;
        #1;
        check("async_rst_data", read_data,          32'h0);
        check("async_rst_rng",  32'(range_error),   32'h0);
        check("async_rst_addr", fault_addr,         32'h0);
        drive(1, 0, 3'b010, 32'h1001_0004, 0, 0); #1;
        check("async_rst_word4", read_data, 32'h0);

        // a store across an edge while reset is low is dropped
        drive(0, 1, 3'b010, 32'h1001_0020, 32'h0000_0077, 0); step();
        #2 reset = 1'b1;
        idle();
        drive(1, 0, 3'b010, 32'h1001_0020, 0, 0); #1;
        check("store_in_reset_dropped", read_data, 32'h0);
        step();
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 64, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-003 SHALL have one clock and an asynchronous active-low reset, declared first:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
REQ-004 SHALL have the remaining ports:
- Mem_Read_i  input  1  load request, combinational
- Mem_Write_i  input  1  store request, takes effect at the next rising clk
- Funct3_i  input  3  access size and signedness, RV32I encoding
- Address_i  input  32  byte address, driven by the ALU result
- Write_Data_i  input  32  store data, from rs2
- Err_Clear_i  input  1  synchronous clear of the sticky error state
- Read_Data_o  output  32  extended load data, combinational
- Misaligned_o  output  1  sticky misalignment flag
- Range_Error_o  output  1  sticky out-of-range flag
- Fault_Addr_o  output  32  address of the first fault since reset or clear

Function
REQ-005 SHALL compute offset = Address_i - BASE_ADDR, word index = offset[31:2], byte lane = offset[1:0]; storage is little-endian.
REQ-006 SHALL treat an access as in range only if BASE_ADDR <= Address_i <= BASE_ADDR + 4*MEMORY_DEPTH - 1.
REQ-007 SHALL decode loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-008 SHALL decode stores: 000 SB, 001 SH, 010 SW; SB writes only the addressed byte lane; SH writes only the addressed halfword; all other bytes are unchanged.
REQ-009 SHALL flag halfword accesses with lane[0]=1, and word accesses with lane != 00, as misaligned.
REQ-010 SHALL suppress a misaligned or out-of-range access: no storage write, and Read_Data_o = 0.
REQ-011 SHALL treat an undefined Funct3 (load 011/110/111; store 011-111) as a no-op: no write, Read_Data_o = 0, no flag set.
REQ-012 SHALL drive Read_Data_o = 0 whenever Mem_Read_i = 0.
REQ-013 SHALL give combinational load data with zero-cycle latency; store data SHALL be visible to a load from the cycle after the clk edge that wrote it.
REQ-014 SHALL, when Mem_Read_i = 1 and Mem_Write_i = 1 in the same cycle, perform the store and drive pre-write data on Read_Data_o in that cycle.
REQ-015 SHALL, for a faulting access on a rising clk, set Misaligned_o and/or Range_Error_o; both flags SHALL be set if both conditions hold.
REQ-016 SHALL load Fault_Addr_o only on the first fault, i.e. when both flags are 0 before the edge; later faults SHALL leave it unchanged.
REQ-017 SHALL, on Err_Clear_i = 1 at a clk edge, clear both flags and Fault_Addr_o, unless a new fault occurs in the same cycle; in that case the new fault SHALL be recorded as a first fault.
REQ-018 SHALL evaluate faults only when Mem_Read_i or Mem_Write_i is 1.

Reset
REQ-019 SHALL, while reset = 0, immediately clear all storage words, Misaligned_o, Range_Error_o and Fault_Addr_o to 0, independent of clk.
REQ-020 SHALL drop a store whose edge coincides with asserted reset; reset SHALL release with the block idle and storage all zero.

Verification
REQ-021 SW 0xDEADBEEF at 0x1001_0004, then LW 0x1001_0004 -> Read_Data_o = 0xDEADBEEF; then LB 0x1001_0007 -> 0xFFFFFFDE; then LBU 0x1001_0007 -> 0x000000DE.
REQ-022 SH 0x1234 at 0x1001_0006 over 0xDEADBEEF, then LW 0x1001_0004 -> 0x1234BEEF; then LH 0x1001_0004 -> 0xFFFFBEEF.
REQ-023 LW 0x1001_0002 -> Read_Data_o = 0 and Misaligned_o = 1 at the next edge with Fault_Addr_o = 0x1001_0002; then SW 0x1001_0101 (MEMORY_DEPTH = 64) -> Range_Error_o = 1, Fault_Addr_o still 0x1001_0002, storage unchanged.
REQ-024 Err_Clear_i = 1 together with SH 0x1001_0003 -> after the edge Misaligned_o = 1, Range_Error_o = 0, Fault_Addr_o = 0x1001_0003.
REQ-025 Read and write 0x55 via SB to 0x1001_0008 in the same cycle -> that cycle shows the old byte; the next cycle LBU shows 0x00000055.
REQ-026 Assert reset = 0 mid-cycle after several stores -> flags and storage read 0 immediately, without a clk edge.
